// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt vector controller: widths, reset vector, FSM states.
package irq_pkg;

  localparam int         IRQ_W     = 8;
  localparam logic [7:0] VEC_RESET = 8'h00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  // Vector for a winning line; 8-bit modulo so bases near 8'hFF wrap silently.
  function automatic logic [7:0] vec_of(input logic [7:0] base, input logic [2:0] idx);
    return base + {5'b00000, idx};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: bit 0 of req wins; any is high when some bit is set.
module irq_prio_enc
  import irq_pkg::*;
(
  input  logic [IRQ_W-1:0] req,
  output logic [2:0]       idx,
  output logic             any
);

  // Scan from the top down so the lowest set bit overwrites the result last.
  always_comb begin
    idx = 3'd0;
    any = |req;
    for (int i = IRQ_W - 1; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/irq_vector_ctrl.sv
// Interrupt controller: synchronises 8 request lines, tracks pending/mask state and
// presents one prioritised vector to the core with an intr/inta/eoi handshake.
module irq_vector_ctrl
  import irq_pkg::*;
#(
  parameter int         NUM_IRQ  = 8,
  parameter logic [7:0] VEC_BASE = 8'h20,
  parameter logic [7:0] EDGE_SEL = 8'hFF
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               inta,
  input  logic               eoi,
  output logic               intr,
  output logic [7:0]         vector,
  output logic [NUM_IRQ-1:0] pending,
  output logic               in_service
);

  logic [NUM_IRQ-1:0] sync_p0, sync_p1, sync_p2;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] set_vec, clr_vec, pending_nxt, eligible;
  logic [2:0]         win_idx, cur_idx, idx_nxt;
  logic               win_any;
  irq_state_e         state, state_nxt;
  logic               intr_nxt, insvc_nxt;
  logic [7:0]         vector_nxt;

  // Stage p0/p1: two-flop synchroniser; p2: previous synchronised value for edge detect.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      sync_p2 <= '0;
    end else begin
      sync_p0 <= irq_in;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  // Edge lines set on a synchronised rising edge, level lines set while high.
  assign set_vec = ((sync_p1 & ~sync_p2) & EDGE_SEL) | (sync_p1 & ~EDGE_SEL);

  // Acknowledge retires the latched line; a simultaneous set still wins below.
  assign clr_vec = (state == REQ && inta) ? (NUM_IRQ'(1) << cur_idx) : '0;

  assign pending_nxt = (pending & ~clr_vec) | set_vec;

  // Arbitration looks at what pending becomes on this edge so a fresh request
  // is presented on the same edge it is recorded.
  assign eligible = pending_nxt & ~mask;

  irq_prio_enc u_prio (
    .req (eligible),
    .idx (win_idx),
    .any (win_any)
  );

  // Pending and mask registers; mask resets to all-masked.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pending <= '0;
      mask    <= '1;
    end else begin
      pending <= pending_nxt;
      if (mask_we) mask <= mask_wdata;
    end
  end

  // FSM state and registered handshake outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      cur_idx    <= 3'd0;
      intr       <= 1'b0;
      in_service <= 1'b0;
      vector     <= VEC_RESET;
    end else begin
      state      <= state_nxt;
      cur_idx    <= idx_nxt;
      intr       <= intr_nxt;
      in_service <= insvc_nxt;
      vector     <= vector_nxt;
    end
  end

  // Next-state logic; vector is captured only when leaving IDLE so it stays frozen in REQ.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = cur_idx;
    intr_nxt   = intr;
    insvc_nxt  = in_service;
    vector_nxt = vector;
    case (state)
      IDLE: begin
        if (win_any) begin
          state_nxt  = REQ;
          idx_nxt    = win_idx;
          intr_nxt   = 1'b1;
          vector_nxt = vec_of(VEC_BASE, win_idx);
        end
      end
      REQ: begin
        if (inta) begin
          state_nxt = SERVICE;
          intr_nxt  = 1'b0;
          insvc_nxt = 1'b1;
        end
      end
      SERVICE: begin
        if (eoi) begin
          state_nxt  = IDLE;
          insvc_nxt  = 1'b0;
          vector_nxt = VEC_RESET;
        end
      end
      default: begin
        state_nxt  = IDLE;
        intr_nxt   = 1'b0;
        insvc_nxt  = 1'b0;
        vector_nxt = VEC_RESET;
      end
    endcase
  end

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Bench for irq_vector_ctrl: cycle model compared every cycle plus directed literal checks.
module tb_irq_vector_ctrl;

  localparam logic [7:0] VB = 8'h20;
  localparam logic [7:0] ES = 8'hFE;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] irq_in = 8'h00;
  logic       mask_we = 1'b0;
  logic [7:0] mask_wdata = 8'h00;
  logic       inta = 1'b0;
  logic       eoi = 1'b0;
  logic       intr, in_service;
  logic [7:0] vector, pending;
  logic       w_intr, w_in_service;
  logic [7:0] w_vector, w_pending;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  irq_vector_ctrl #(.NUM_IRQ(8), .VEC_BASE(VB), .EDGE_SEL(ES)) dut (
    .clk(clk), .clr(clr), .irq_in(irq_in), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .inta(inta), .eoi(eoi), .intr(intr), .vector(vector), .pending(pending),
    .in_service(in_service)
  );

  // Second instance with a base near the top to exercise vector wrap.
  irq_vector_ctrl #(.NUM_IRQ(8), .VEC_BASE(8'hFC), .EDGE_SEL(8'hFF)) dut_w (
    .clk(clk), .clr(clr), .irq_in(irq_in), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .inta(inta), .eoi(eoi), .intr(w_intr), .vector(w_vector), .pending(w_pending),
    .in_service(w_in_service)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: irq seen two edges late, pending set/clear, one request at a time.
  logic [7:0] m_s1 = 8'h00, m_s2 = 8'h00, m_s3 = 8'h00;
  logic [7:0] m_pend = 8'h00, m_mask = 8'hFF;
  int         m_phase = 0;  // 0 idle, 1 requesting, 2 being serviced
  int         m_line = 0;

  always @(posedge clk or posedge clr) begin
    logic [7:0] sets, clrb, np, elig;
    if (clr) begin
      m_s1 = 0; m_s2 = 0; m_s3 = 0; m_pend = 0; m_mask = 8'hFF; m_phase = 0; m_line = 0;
    end else begin
      sets = 8'h00;
      for (int i = 0; i < 8; i++)
        sets[i] = ES[i] ? (m_s2[i] && !m_s3[i]) : m_s2[i];
      clrb = 8'h00;
      if (m_phase == 1 && inta) clrb[m_line] = 1'b1;
      np = (m_pend & ~clrb) | sets;
      elig = np & ~m_mask;
      if (m_phase == 0) begin
        if (elig != 8'h00) begin
          for (int i = 7; i >= 0; i--) if (elig[i]) m_line = i;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (inta) m_phase = 2;
      end else begin
        if (eoi) m_phase = 0;
      end
      m_pend = np;
      if (mask_we) m_mask = mask_wdata;
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = irq_in;
    end
  end

  // Compare every cycle, shortly after the active edge.
  always @(posedge clk) begin
    #1;
    chk("m_intr", {7'b0, intr}, {7'b0, (m_phase == 1)});
    chk("m_insvc", {7'b0, in_service}, {7'b0, (m_phase == 2)});
    chk("m_vector", vector, (m_phase != 0) ? 8'(int'(VB) + m_line) : 8'h00);
    chk("m_pending", pending, m_pend);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_inta();
    inta = 1'b1; cyc(1); inta = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1; cyc(1); eoi = 1'b0;
  endtask

  task automatic wr_mask(input logic [7:0] v);
    mask_we = 1'b1; mask_wdata = v; cyc(1); mask_we = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 30; k++) begin
      if (intr) inta = 1'b1;
      else if (in_service) eoi = 1'b1;
      cyc(1);
      inta = 1'b0; eoi = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    cyc(2);
    chk("rst_intr", {7'b0, intr}, 8'h00);
    chk("rst_vector", vector, 8'h00);
    chk("rst_pending", pending, 8'h00);
    chk("rst_insvc", {7'b0, in_service}, 8'h00);
    clr = 1'b0;
    cyc(1);

    // Wrap: line 7 on base FC gives 03, on base 20 gives 27.
    wr_mask(8'h7F);
    irq_in = 8'h80; cyc(1); irq_in = 8'h00; cyc(2);
    chk("wrap_vec", w_vector, 8'h03);
    chk("base_vec7", vector, 8'h27);
    pulse_inta(); pulse_eoi();
    wr_mask(8'h00);

    // Single edge request on line 3.
    irq_in = 8'h08; cyc(1); irq_in = 8'h00; cyc(1);
    chk("edge_lat2", {7'b0, intr}, 8'h00);
    cyc(1);
    chk("edge_intr", {7'b0, intr}, 8'h01);
    chk("edge_vec", vector, 8'h23);
    chk("edge_pend", pending, 8'h08);
    pulse_inta();
    chk("ack_intr", {7'b0, intr}, 8'h00);
    chk("ack_insvc", {7'b0, in_service}, 8'h01);
    chk("ack_vec", vector, 8'h23);
    pulse_eoi();
    chk("eoi_vec", vector, 8'h00);
    chk("eoi_insvc", {7'b0, in_service}, 8'h00);

    // Priority: lines 5 and 1 together.
    irq_in = 8'h22; cyc(3);
    chk("prio_vec", vector, 8'h21);
    pulse_inta();
    chk("prio_pend", pending, 8'h20);
    pulse_eoi();
    chk("prio_gap", {7'b0, intr}, 8'h00);
    cyc(1);
    chk("prio_next", vector, 8'h25);
    pulse_inta(); pulse_eoi();
    irq_in = 8'h00; cyc(3);

    // Freeze: line 0 arrives while line 6 is requesting.
    irq_in = 8'h40; cyc(3);
    chk("frz_vec0", vector, 8'h26);
    irq_in = 8'h41; cyc(4);
    chk("frz_vec1", vector, 8'h26);
    chk("frz_pend", pending, 8'h41);
    pulse_inta();
    chk("frz_pend2", pending, 8'h01);
    pulse_eoi(); cyc(1);
    chk("frz_next", vector, 8'h20);
    irq_in = 8'h00;
    drain();
    chk("frz_done", pending, 8'h00);

    // Mask holds a pending line back until unmasked.
    wr_mask(8'h04);
    irq_in = 8'h04; cyc(1); irq_in = 8'h00; cyc(5);
    chk("msk_pend", pending, 8'h04);
    chk("msk_intr", {7'b0, intr}, 8'h00);
    wr_mask(8'h00);
    chk("msk_same", {7'b0, intr}, 8'h00);
    cyc(1);
    chk("msk_intr2", {7'b0, intr}, 8'h01);
    chk("msk_vec", vector, 8'h22);
    drain();

    // Level line 0 held high re-sets pending and re-requests.
    irq_in = 8'h01; cyc(3);
    chk("lvl_vec", vector, 8'h20);
    pulse_inta();
    chk("lvl_pend", pending, 8'h01);
    pulse_eoi();
    chk("lvl_idle", vector, 8'h00);
    cyc(1);
    chk("lvl_again", vector, 8'h20);
    pulse_eoi();
    chk("eoi_in_req", {7'b0, intr}, 8'h01);
    inta = 1'b1; eoi = 1'b1; cyc(1); inta = 1'b0; eoi = 1'b0;
    chk("both_insvc", {7'b0, in_service}, 8'h01);
    pulse_inta();
    chk("inta_in_svc", {7'b0, in_service}, 8'h01);
    irq_in = 8'h00;
    drain();
    chk("lvl_done", pending, 8'h00);

    // Asynchronous reset in the middle of a request.
    irq_in = 8'h10; cyc(1); irq_in = 8'h00; cyc(2);
    chk("pre_rst_vec", vector, 8'h24);
    #2 clr = 1'b1;
    #1;
    chk("arst_intr", {7'b0, intr}, 8'h00);
    chk("arst_vec", vector, 8'h00);
    chk("arst_pend", pending, 8'h00);
    cyc(1);
    clr = 1'b0;
    irq_in = 8'h08; cyc(1); irq_in = 8'h00; cyc(4);
    chk("arst_mask_pend", pending, 8'h08);
    chk("arst_mask_intr", {7'b0, intr}, 8'h00);
    wr_mask(8'h00); cyc(1);
    chk("arst_unmask", vector, 8'h23);
    drain();

    // Mixed patterns left to the cycle model.
    wr_mask(8'h0F); irq_in = 8'hFE; cyc(1); irq_in = 8'h00; drain();
    wr_mask(8'h00); irq_in = 8'h81; cyc(1); irq_in = 8'h00; drain();
    irq_in = 8'h18; cyc(2); irq_in = 8'h00; drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
